pwm_bank: RTL and testbench
===========================

PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 Parameter CHANNELS, default 3, SHALL set the number of independent PWM outputs (1..16).
REQ-002 Parameter WIDTH, default 8, SHALL set the counter and level width in bits (2..16).
REQ-003 Parameter INVERT, default 0, SHALL be a CHANNELS-bit mask; a set bit inverts that channel's output.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be synchronous and active-high.
REQ-006 level_data  input  WIDTH  SHALL carry the duty level to write.
REQ-007 level_sel  input  max(1,$clog2(CHANNELS))  SHALL select the target channel of a write.
REQ-008 level_valid  input  1  SHALL qualify a write when high.
REQ-009 center  input  1  SHALL request the mode: 0 = edge-aligned, 1 = center-aligned.
REQ-010 out  output  CHANNELS  SHALL carry the PWM waveforms; bit i belongs to channel i.
REQ-011 period_start  output  1  SHALL be high during every cycle in which the counter equals 0.

Function
REQ-012 Let MAX = 2^WIDTH-1; the counter SHALL be WIDTH bits, with one direction flag used only in center mode.
REQ-013 Edge mode: the counter SHALL count 0,1,...,MAX and then wrap to 0, giving a period of 2^WIDTH cycles.
REQ-014 Center mode: the counter SHALL count 0 up to MAX and then down to 1, giving a period of 2*MAX cycles.
REQ-015 Raw duty for channel i SHALL be (counter < active[i]), compared unsigned; out[i] SHALL be raw duty XOR INVERT[i].
REQ-016 Resulting duty: edge mode gives L of 2^WIDTH cycles high; center mode gives max(0,2L-1) of 2*MAX cycles high, centred on counter==0.
REQ-017 Level 0 SHALL hold raw duty low for the whole period; level MAX in edge mode SHALL give MAX of 2^WIDTH cycles high (full on is not reachable).
REQ-018 A write with level_valid=1 SHALL store level_data into shadow[level_sel] at that edge.
REQ-019 A write with level_sel >= CHANNELS SHALL be ignored.
REQ-020 Boundary: the edge that makes the counter 0 (from MAX in edge mode, from 1 in center mode).
  - At the boundary, active[i] <= shadow[i] for all channels, and mode <= center.
  - A new level or mode therefore takes effect in the cycle where counter==0.
REQ-021 A write on the boundary edge SHALL land in the shadow only; active SHALL take the pre-write shadow value, and the new value SHALL apply at the next boundary.
REQ-022 Multiple writes to one channel within a period: the last write SHALL win.
REQ-023 A change on center between boundaries SHALL have no effect until the next boundary.
REQ-024 On a mode switch at the boundary, the counter SHALL restart at 0 with direction up.
REQ-025 Outputs SHALL be combinational from registers only; no input-to-output combinational path.

Reset
REQ-026 While reset is high at a clock edge:
  - counter <= 0, direction <= up, mode <= edge.
  - all shadow and active levels <= 0.
REQ-027 After reset:
  - out SHALL equal INVERT.
  - period_start SHALL be 1 in the first cycle after reset deasserts.
REQ-028 A reset mid-period SHALL discard pending shadow writes and abort the current period without completing it.

Structure
REQ-029 A shared package/header SHALL hold the mode constants MODE_EDGE=0 and MODE_CENTER=1.
REQ-030 The counter and direction logic SHALL live in pwm_bank and be shared by all channels.
REQ-031 A sub-module pwm_channel SHALL hold one channel's shadow register, active register and comparator; it is instantiated CHANNELS times via generate.

Verification (CHANNELS=3, WIDTH=8, INVERT=3'b100)
REQ-032 Reset released, no writes -> out=3'b100 constant for 512 cycles; period_start every 256 cycles.
REQ-033 Write ch0=64 mid-period -> out[0] low until the next counter==0, then exactly 64 high of every 256 cycles.
REQ-034 Write ch1=10 on the boundary edge -> old ch1 level for one more period, 10 from the following period.
REQ-035 center=1 with ch2=100 -> after the boundary, period 510 cycles; out[2] low for 199 cycles per period (inverted); period_start every 510 cycles.
REQ-036 level_sel=3 with level_valid=1 -> no channel changes; ch0=255 in edge mode -> 255 high, 1 low per period.
REQ-037 Reset asserted at counter=150 with pending shadow writes -> next period all raw duties 0 and out=3'b100.

Source files
------------

// File: rtl/pwm_bank_pkg.sv
// -----------------------------------------------------------------------------
// pwm_bank_pkg
//   Shared definitions for the PWM bank: the counting-mode encoding, the
//   counter direction encoding and a helper that sizes the channel-select bus.
//   Imported by pwm_bank and pwm_channel.
// -----------------------------------------------------------------------------
package pwm_bank_pkg;

  // Counting mode of the shared period counter.
  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTER = 1'b1
  } pwm_mode_e;

  // Direction of the shared counter; only meaningful in center mode.
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } pwm_dir_e;

  // Width of a bus able to address every channel, never narrower than one bit.
  function automatic int selWidth(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// -----------------------------------------------------------------------------
// pwm_channel
//   One PWM channel: a shadow level register written by the host, an active
//   level register reloaded from the shadow at each period boundary, and the
//   comparator that turns the shared counter into this channel's waveform.
//
// Ports
//   i_clk    : clock, all state changes on the rising edge
//   i_reset  : synchronous active-high reset, clears both level registers
//   i_write  : store i_data into the shadow register at this edge
//   i_data   : level to store
//   i_load   : period boundary; copy the shadow into the active register
//   i_count  : shared period counter value (registered in the parent)
//   o_pwm    : PWM output, already polarity-adjusted by INVERT
// -----------------------------------------------------------------------------
module pwm_channel
  import pwm_bank_pkg::*;
#(
  parameter int   WIDTH  = 8,
  parameter logic INVERT = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_write,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_count,
  output logic             o_pwm
);

  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] r_active;
  logic             w_raw;

  // The active register samples the shadow as it was before this edge, so a
  // write landing on the boundary edge is held back for one full period.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_shadow <= '0;
      r_active <= '0;
    end else begin
      if (i_write) begin
        r_shadow <= i_data;
      end
      if (i_load) begin
        r_active <= r_shadow;
      end
    end
  end

  // Counter and active level are both registers, so the output has no
  // combinational path from any input port.
  assign w_raw = (i_count < r_active);
  assign o_pwm = w_raw ^ INVERT;

endmodule

// File: rtl/pwm_bank.sv
// -----------------------------------------------------------------------------
// pwm_bank
//   Bank of CHANNELS PWM outputs sharing one period counter. The counter runs
//   either edge-aligned (0..MAX, wrap) or center-aligned (0 up to MAX, back
//   down to 1). Levels and mode are double-buffered: writes go to per-channel
//   shadow registers and the requested mode is sampled only at the period
//   boundary, i.e. the edge that returns the counter to 0.
//
// Ports
//   clk          : clock
//   reset        : synchronous active-high reset
//   level_data   : duty level to write
//   level_sel    : channel targeted by a write; values >= CHANNELS are dropped
//   level_valid  : qualifies a write
//   center       : requested mode, 0 = edge-aligned, 1 = center-aligned
//   out          : PWM waveforms, bit i belongs to channel i
//   period_start : high in every cycle where the counter is 0
// -----------------------------------------------------------------------------
module pwm_bank
  import pwm_bank_pkg::*;
#(
  parameter int                  CHANNELS = 3,
  parameter int                  WIDTH    = 8,
  parameter logic [CHANNELS-1:0] INVERT   = '0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [WIDTH-1:0]                  level_data,
  input  logic [selWidth(CHANNELS)-1:0]     level_sel,
  input  logic                              level_valid,
  input  logic                              center,
  output logic [CHANNELS-1:0]               out,
  output logic                              period_start
);

  localparam int               SEL_W     = selWidth(CHANNELS);
  localparam logic [WIDTH-1:0] MAX_COUNT = '1;
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  pwm_dir_e         r_dir;
  pwm_mode_e        r_mode;
  logic             w_boundary;

  // The boundary is the edge that brings the counter back to 0: from MAX in
  // edge mode, or from 1 on the way down in center mode.
  always_comb begin
    w_boundary = 1'b0;
    if (r_mode == MODE_EDGE) begin
      w_boundary = (r_count == MAX_COUNT);
    end else begin
      w_boundary = (r_dir == DIR_DOWN) && (r_count == ONE);
    end
  end

  // Shared counter. At the boundary the mode request is latched and the
  // counter always restarts at 0 heading up, so a mode switch begins a clean
  // period in the new mode. In center mode the turn at MAX goes straight to
  // MAX-1, giving 0..MAX then MAX-1..1, i.e. 2*MAX cycles per period.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_dir   <= DIR_UP;
      r_mode  <= MODE_EDGE;
    end else if (w_boundary) begin
      r_count <= '0;
      r_dir   <= DIR_UP;
      r_mode  <= center ? MODE_CENTER : MODE_EDGE;
    end else if (r_mode == MODE_EDGE) begin
      r_count <= r_count + ONE;
    end else if (r_dir == DIR_UP) begin
      if (r_count == MAX_COUNT) begin
        r_dir   <= DIR_DOWN;
        r_count <= r_count - ONE;
      end else begin
        r_count <= r_count + ONE;
      end
    end else begin
      r_count <= r_count - ONE;
    end
  end

  assign period_start = (r_count == '0);

  // One channel per output bit. The select decode compares against each
  // channel's own index, so out-of-range selects match no channel at all.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    localparam logic [SEL_W-1:0] CH_SEL = SEL_W'(gi);
    logic w_write;

    assign w_write = level_valid && (level_sel == CH_SEL);

    pwm_channel #(
      .WIDTH  (WIDTH),
      .INVERT (INVERT[gi])
    ) u_chan (
      .i_clk   (clk),
      .i_reset (reset),
      .i_write (w_write),
      .i_data  (level_data),
      .i_load  (w_boundary),
      .i_count (r_count),
      .o_pwm   (out[gi])
    );
  end

endmodule

// File: tb/tb_pwm_bank.sv
// -----------------------------------------------------------------------------
// tb_pwm_bank
//   Self-checking bench for pwm_bank (CHANNELS=3, WIDTH=8, INVERT=3'b100).
//   Scenario tasks push the expected shape of each upcoming period (length and
//   high-cycle count per output) onto a queue; a monitor measures each period
//   between period_start pulses and compares it with the popped entry.
// -----------------------------------------------------------------------------
module tb_pwm_bank;

  localparam int             CH   = 3;
  localparam int             W    = 8;
  localparam int             MAXV = (1 << W) - 1;
  localparam logic [CH-1:0]  INV  = 3'b100;

  typedef struct {
    int len;
    int hi0;
    int hi1;
    int hi2;
  } period_t;

  logic           clk;
  logic           reset;
  logic [W-1:0]   level_data;
  logic [1:0]     level_sel;
  logic           level_valid;
  logic           center;
  logic [CH-1:0]  out;
  logic           period_start;

  int      checks = 0;
  int      errors = 0;
  period_t expQ[$];

  int      monLen;
  int      monHi[CH];
  bit      inPeriod = 1'b0;
  logic    rstAtEdge;
  int      periodIdx = 0;

  pwm_bank #(
    .CHANNELS (CH),
    .WIDTH    (W),
    .INVERT   (INV)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .level_data   (level_data),
    .level_sel    (level_sel),
    .level_valid  (level_valid),
    .center       (center),
    .out          (out),
    .period_start (period_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Raw high cycles per period for a level, straight from the duty rules.
  function automatic int rawHigh(input bit isCenter, input int lvl);
    if (isCenter) return (lvl == 0) ? 0 : 2 * lvl - 1;
    return lvl;
  endfunction

  function automatic int outHigh(input bit isCenter, input int lvl, input int ch);
    logic [CH-1:0] inv;
    int len;
    int raw;
    inv = INV;
    len = isCenter ? 2 * MAXV : MAXV + 1;
    raw = rawHigh(isCenter, lvl);
    return inv[ch] ? len - raw : raw;
  endfunction

  task automatic pushPeriod(input bit isCenter, input int l0, input int l1, input int l2);
    period_t p;
    p.len = isCenter ? 2 * MAXV : MAXV + 1;
    p.hi0 = outHigh(isCenter, l0, 0);
    p.hi1 = outHigh(isCenter, l1, 1);
    p.hi2 = outHigh(isCenter, l2, 2);
    expQ.push_back(p);
  endtask

  // Period monitor: samples 1 time unit after each rising edge. A reset edge
  // discards any partial period and starts measuring afresh.
  always @(posedge clk) begin
    rstAtEdge = reset;
    #1;
    if (rstAtEdge === 1'b1) begin
      inPeriod = 1'b1;
      monLen = 1;
      for (int i = 0; i < CH; i++) monHi[i] = (out[i] === 1'b1) ? 1 : 0;
    end else if (inPeriod) begin
      if (period_start === 1'b1) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_period #%0d: got period of %0d cycles, required none", periodIdx, monLen);
        end else begin
          period_t e;
          int eh[CH];
          e = expQ.pop_front();
          eh[0] = e.hi0;
          eh[1] = e.hi1;
          eh[2] = e.hi2;
          checks++;
          if (monLen !== e.len) begin
            errors++;
            $display("[TB] FAIL period_len #%0d: got %0d, required %0d", periodIdx, monLen, e.len);
          end
          for (int i = 0; i < CH; i++) begin
            checks++;
            if (monHi[i] !== eh[i]) begin
              errors++;
              $display("[TB] FAIL high_count #%0d ch%0d: got %0d, required %0d", periodIdx, i, monHi[i], eh[i]);
            end
          end
        end
        periodIdx++;
        monLen = 1;
        for (int i = 0; i < CH; i++) monHi[i] = (out[i] === 1'b1) ? 1 : 0;
      end else begin
        monLen++;
        for (int i = 0; i < CH; i++) monHi[i] += (out[i] === 1'b1) ? 1 : 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic writeLevel(input logic [1:0] sel, input logic [W-1:0] data);
    level_sel   = sel;
    level_data  = data;
    level_valid = 1'b1;
    @(negedge clk);
    level_valid = 1'b0;
  endtask

  // Advance to the next cycle with counter 0, bounded so a stuck counter ends the run.
  task automatic nextPeriod();
    int n;
    n = 0;
    @(negedge clk);
    while (period_start !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (period_start !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL period_timeout: got no period_start in %0d cycles, required one", n);
    end
  endtask

  task automatic test_reset();
    tick(3);
    checks++;
    if (out !== 3'b100) begin
      errors++;
      $display("[TB] FAIL reset_out: got %b, required 100", out);
    end
    checks++;
    if (period_start !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_period_start: got %b, required 1", period_start);
    end
    reset = 1'b0;
    checks++;
    if (period_start !== 1'b1) begin
      errors++;
      $display("[TB] FAIL first_cycle_period_start: got %b, required 1", period_start);
    end
  endtask

  task automatic test_idle();
    pushPeriod(1'b0, 0, 0, 0);
    pushPeriod(1'b0, 0, 0, 0);
    tick(77);
    checks++;
    if (out !== 3'b100) begin
      errors++;
      $display("[TB] FAIL idle_out: got %b, required 100", out);
    end
    nextPeriod();
    nextPeriod();
  endtask

  task automatic test_mid_write();
    pushPeriod(1'b0, 0, 0, 0);
    tick(100);
    writeLevel(2'd0, 8'd64);
    pushPeriod(1'b0, 64, 0, 0);
    nextPeriod();
  endtask

  task automatic test_boundary_write();
    tick(255);
    writeLevel(2'd1, 8'd10);
    checks++;
    if (period_start !== 1'b1) begin
      errors++;
      $display("[TB] FAIL boundary_align: got period_start %b, required 1", period_start);
    end
    pushPeriod(1'b0, 64, 0, 0);
    nextPeriod();
    pushPeriod(1'b0, 64, 10, 0);
    nextPeriod();
  endtask

  task automatic test_invalid_sel();
    pushPeriod(1'b0, 64, 10, 0);
    tick(20);
    writeLevel(2'd3, 8'd200);
    writeLevel(2'd0, 8'd255);
    tick(10);
    writeLevel(2'd1, 8'd50);
    writeLevel(2'd1, 8'd30);
    pushPeriod(1'b0, 255, 30, 0);
    nextPeriod();
    nextPeriod();
  endtask

  task automatic test_center();
    pushPeriod(1'b0, 255, 30, 0);
    tick(50);
    center = 1'b1;
    tick(10);
    writeLevel(2'd2, 8'd100);
    nextPeriod();
    pushPeriod(1'b1, 255, 30, 100);
    tick(100);
    center = 1'b0;
    tick(5);
    center = 1'b1;
    nextPeriod();
    pushPeriod(1'b1, 255, 30, 100);
    tick(30);
    center = 1'b0;
    nextPeriod();
    pushPeriod(1'b0, 255, 30, 100);
    nextPeriod();
  endtask

  task automatic test_reset_mid();
    tick(149);
    writeLevel(2'd0, 8'd77);
    reset = 1'b1;
    tick(3);
    checks++;
    if (out !== 3'b100) begin
      errors++;
      $display("[TB] FAIL reset_mid_out: got %b, required 100", out);
    end
    reset = 1'b0;
    checks++;
    if (period_start !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_mid_period_start: got %b, required 1", period_start);
    end
    pushPeriod(1'b0, 0, 0, 0);
    nextPeriod();
  endtask

  initial begin
    reset       = 1'b1;
    level_data  = '0;
    level_sel   = '0;
    level_valid = 1'b0;
    center      = 1'b0;
    test_reset();
    test_idle();
    test_mid_write();
    test_boundary_write();
    test_invalid_sel();
    test_center();
    test_reset_mid();
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL unobserved_periods: got %0d pending, required 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
